// File: rtl/uart_tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// uart_tick_gen_pkg
//   Shared constants and types for the UART tick generator.
//   - Default counter width and oversample ratio.
//   - Divisor constants for 9600 and 115200 baud from a 50 MHz system clock.
//   - calc_div(): rounded divisor for an arbitrary clock / baud / oversample.
//   - ticks_t: the three registered strobes as one bundle.
//   - apply_src_e: why a pending divisor is being committed this cycle.
// -----------------------------------------------------------------------------
package uart_tick_gen_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int CLK_HZ_DEF     = 50_000_000;

  // Divisor = clk_hz / (baud * os), rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

  // 50 MHz / (115200 * 16) = 27.13 -> 27
  localparam int DIV_115200_50M = calc_div(CLK_HZ_DEF, 115_200, OVERSAMPLE_DEF);
  // 50 MHz / (9600 * 16)   = 325.52 -> 326
  localparam int DIV_9600_50M   = calc_div(CLK_HZ_DEF, 9_600, OVERSAMPLE_DEF);

  typedef struct packed {
    logic os;       // oversample strobe
    logic mid;      // mid-bit strobe
    logic bit_end;  // bit-boundary strobe
  } ticks_t;

  // Reason a pending divisor gets committed; NONE means keep waiting.
  typedef enum logic [1:0] {
    APPLY_NONE    = 2'd0,
    APPLY_WRAP    = 2'd1,
    APPLY_RESTART = 2'd2,
    APPLY_IDLE    = 2'd3
  } apply_src_e;

endpackage : uart_tick_gen_pkg

// File: rtl/uart_tick_gen_if.sv
// -----------------------------------------------------------------------------
// uart_tick_gen_if
//   Control / strobe bundle between the UART core and the tick generator.
//   master : the UART core (drives enable, divisor programming, restart;
//            consumes the strobes and the active divisor)
//   slave  : uart_tick_gen
//   Signals
//     enable        1      run (1) / idle with counters cleared (0)
//     div_val       CNT_W  divisor to program
//     div_load      1      one-cycle strobe, capture div_val into shadow
//     sync_restart  1      one-cycle strobe, realign phase (rx start edge)
//     tick_os       1      oversample strobe
//     tick_mid      1      mid-bit strobe
//     tick_bit      1      bit-end strobe
//     div_cur       CNT_W  divisor currently in use
// -----------------------------------------------------------------------------
interface uart_tick_gen_if
  import uart_tick_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             enable;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             sync_restart;
  logic             tick_os;
  logic             tick_mid;
  logic             tick_bit;
  logic [CNT_W-1:0] div_cur;

  modport master (
    output enable,
    output div_val,
    output div_load,
    output sync_restart,
    input  tick_os,
    input  tick_mid,
    input  tick_bit,
    input  div_cur
  );

  modport slave (
    input  enable,
    input  div_val,
    input  div_load,
    input  sync_restart,
    output tick_os,
    output tick_mid,
    output tick_bit,
    output div_cur
  );

endinterface : uart_tick_gen_if

// File: rtl/uart_tick_gen_tick_counter.sv
// -----------------------------------------------------------------------------
// tick_counter
//   Modulo counter 0..last with synchronous clear and count enable.
//   The terminal count is supplied as 'last' (modulus - 1) so a modulus equal
//   to 2**W still fits in W bits.
//   Ports
//     clk      in   1  system clock
//     reset_n  in   1  asynchronous active-low reset, counter -> 0
//     clr      in   1  synchronous clear, wins over en
//     en       in   1  advance by one this cycle
//     last     in   W  terminal count (modulus - 1)
//     cnt      out  W  current count
//     wrap     out  1  combinational: this enabled edge takes cnt from last to 0
// -----------------------------------------------------------------------------
module tick_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  // '>=' rather than '==' so a count that somehow sits above the terminal
  // value still returns to zero on the next enabled edge instead of running
  // all the way round the W-bit range.
  assign wrap = en && !clr && (cnt_reg >= last);

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = wrap ? '0 : cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule : tick_counter

// File: rtl/uart_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_tick_gen
//   Runtime-programmable baud tick generator for uart_rx / uart_tx.
//   A base counter divides clk by N = max(div_cur, 1); every wrap produces one
//   oversample strobe. A second counter counts those strobes modulo OVERSAMPLE
//   to place the mid-bit and bit-end strobes. All strobes are registered and
//   exactly one clk cycle wide.
//
//   The divisor is double-buffered: div_load fills a shadow register and the
//   shadow only reaches div_cur at a point where the base counter is zero
//   anyway (regular wrap, sync_restart, or while disabled). A reload therefore
//   never shortens or stretches the period in progress and never emits an
//   extra strobe.
//
//   Parameters
//     CNT_W        width of divisor and base counter
//     OVERSAMPLE   tick_os strobes per bit, 2..256
//     DEFAULT_DIV  divisor loaded by reset
//   Ports
//     clk      in  system clock, posedge
//     reset_n  in  asynchronous active-low reset
//     bus      uart_tick_gen_if.slave (controls in, strobes/div_cur out)
// -----------------------------------------------------------------------------
module uart_tick_gen
  import uart_tick_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int DEFAULT_DIV = DIV_115200_50M
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tick_gen_if.slave  bus
);

  // os_cnt only has to reach OVERSAMPLE-1, so $clog2 is exactly enough
  // (16 -> 4 bits, 256 -> 8 bits).
  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [OS_W-1:0]  OS_LAST     = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] DIV_RST     = CNT_W'(DEFAULT_DIV);

  // ---------------------------------------------------------------------------
  // Divisor registers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] shadow_reg;
  logic [CNT_W-1:0] shadow_next;
  logic             pend_reg;
  logic             pend_next;
  logic [CNT_W-1:0] div_cur_reg;
  logic [CNT_W-1:0] div_cur_next;

  // ---------------------------------------------------------------------------
  // Counter plumbing
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_last;
  logic             cnt_clr;
  logic             cnt_wrap;
  logic [CNT_W-1:0] base_cnt_unused;
  logic [OS_W-1:0]  os_cnt;
  logic             os_wrap;

  apply_src_e       apply_src;

  // ---------------------------------------------------------------------------
  // Strobe registers
  // ---------------------------------------------------------------------------
  ticks_t           ticks_reg;
  ticks_t           ticks_next;

  // Divisor 0 behaves as 1: terminal count 0, so the base counter wraps on
  // every enabled edge.
  always_comb begin
    cnt_last = '0;
    if (div_cur_reg != '0) begin
      cnt_last = div_cur_reg - CNT_W'(1);
    end
  end

  // Idle and restart both park the counters at zero; restart has to lose to
  // enable=0 but that falls out naturally because both clear.
  assign cnt_clr = !bus.enable || bus.sync_restart;

  tick_counter #(
    .W (CNT_W)
  ) u_base_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (bus.enable),
    .last    (cnt_last),
    .cnt     (base_cnt_unused),
    .wrap    (cnt_wrap)
  );

  // Advances once per oversample period; its own wrap marks the bit end.
  tick_counter #(
    .W (OS_W)
  ) u_os_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_wrap),
    .last    (OS_LAST),
    .cnt     (os_cnt),
    .wrap    (os_wrap)
  );

  // ---------------------------------------------------------------------------
  // Commit point for a pending divisor, in priority order.
  // ---------------------------------------------------------------------------
  always_comb begin
    apply_src = APPLY_NONE;
    if (!bus.enable) begin
      apply_src = APPLY_IDLE;
    end else if (bus.sync_restart) begin
      apply_src = APPLY_RESTART;
    end else if (cnt_wrap) begin
      apply_src = APPLY_WRAP;
    end
  end

  // A load on the same edge as a commit is folded in first, so the freshly
  // presented div_val is what gets committed. Repeated loads before a commit
  // simply overwrite the shadow.
  always_comb begin
    shadow_next  = shadow_reg;
    pend_next    = pend_reg;
    div_cur_next = div_cur_reg;
    if (bus.div_load) begin
      shadow_next = bus.div_val;
      pend_next   = 1'b1;
    end
    if ((apply_src != APPLY_NONE) && pend_next) begin
      div_cur_next = shadow_next;
      pend_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_reg  <= DIV_RST;
      pend_reg    <= 1'b0;
      div_cur_reg <= DIV_RST;
    end else begin
      shadow_reg  <= shadow_next;
      pend_reg    <= pend_next;
      div_cur_reg <= div_cur_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe generation. Restart and idle force all strobes low for the
  // following cycle, even if the base counter happened to be at its terminal
  // count on that edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    ticks_next = '0;
    if (bus.enable && !bus.sync_restart) begin
      ticks_next.os      = cnt_wrap;
      ticks_next.mid     = cnt_wrap && (os_cnt == OS_MID_LAST);
      ticks_next.bit_end = os_wrap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ticks_reg <= '0;
    end else begin
      ticks_reg <= ticks_next;
    end
  end

  assign bus.tick_os  = ticks_reg.os;
  assign bus.tick_mid = ticks_reg.mid;
  assign bus.tick_bit = ticks_reg.bit_end;
  assign bus.div_cur  = div_cur_reg;

endmodule : uart_tick_gen

// File: tb/tb_uart_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_tick_gen
//   Directed bench for uart_tick_gen (CNT_W=16, OVERSAMPLE=16, DEFAULT_DIV=27).
//   Each stimulus step pushes the clk cycles at which strobes must appear into
//   a scoreboard queue; a negedge monitor pops the head when its cycle arrives
//   and requires all-zero strobes on every other cycle.
//   'cyc' counts posedges; strobes registered on posedge k are seen while
//   cyc == k. Stimulus is applied 2 time units after a posedge.
// -----------------------------------------------------------------------------
module tb_uart_tick_gen;
  import uart_tick_gen_pkg::*;

  localparam int OS = 16;

  typedef struct {
    int         cyc;
    logic [2:0] t;   // {os, mid, bit}
  } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  sb_q[$];

  uart_tick_gen_if #(.CNT_W(16)) bus();

  uart_tick_gen #(
    .CNT_W       (16),
    .OVERSAMPLE  (OS),
    .DEFAULT_DIV (27)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  // k-th oversample strobe since the oversample counter was last zeroed.
  task automatic push_ev(input int c, input int k);
    ev_t e;
    e.cyc = c;
    e.t   = {1'b1, ((k % OS) == OS / 2), ((k % OS) == 0)};
    sb_q.push_back(e);
  endtask

  task automatic push_run(input int base, input int n, input int count);
    for (int k = 1; k <= count; k++) push_ev(base + k * n, k);
  endtask

  // Scoreboard monitor, one line per strobe transaction.
  always @(negedge clk) begin : mon
    logic [2:0] exp_t;
    logic [2:0] obs_t;
    exp_t = 3'b000;
    if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
      exp_t = sb_q[0].t;
      void'(sb_q.pop_front());
    end
    obs_t = {bus.tick_os, bus.tick_mid, bus.tick_bit};
    checks++;
    assert (obs_t === exp_t) else begin
      failures++;
      $error("FAIL ticks cyc=%0d observed=%b expected=%b", cyc, obs_t, exp_t);
    end
    if (exp_t != 3'b000)
      $display("tick cyc=%0d os/mid/bit=%b div_cur=%0d", cyc, obs_t, bus.div_cur);
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "bench did not terminate");
  end

  initial begin : stim
    int p, q, r, s, t, u;
    reset_n          = 1'b0;
    bus.enable       = 1'b0;
    bus.div_val      = '0;
    bus.div_load     = 1'b0;
    bus.sync_restart = 1'b0;
    tick();
    tick();
    chk("rst_div_cur", bus.div_cur, 27);
    chk("rst_tick_os", bus.tick_os, 0);
    chk("rst_tick_mid", bus.tick_mid, 0);
    chk("rst_tick_bit", bus.tick_bit, 0);

    // 1: N=27, two full bit frames.
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    p = cyc;
    push_run(p, 27, 32);
    wait_until(p + 864);
    chk("t1_div_cur", bus.div_cur, 27);

    // 2: divisor 0 then 1, loaded while disabled.
    bus.enable   = 1'b0;
    bus.div_val  = 16'd0;
    bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    chk("t2_div0_applied", bus.div_cur, 0);
    tick();
    tick();
    q = cyc;
    bus.enable = 1'b1;
    push_run(q, 1, 34);
    wait_until(q + 34);
    bus.enable   = 1'b0;
    bus.div_val  = 16'd1;
    bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    chk("t2_div1_applied", bus.div_cur, 1);
    tick();
    r = cyc;
    bus.enable = 1'b1;
    push_run(r, 1, 16);
    wait_until(r + 16);

    // 3: N=10 running, reload 4 at cnt=3.
    bus.enable   = 1'b0;
    bus.div_val  = 16'd10;
    bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    chk("t3_div10_applied", bus.div_cur, 10);
    tick();
    s = cyc;
    bus.enable = 1'b1;
    push_ev(s + 10, 1);
    for (int j = 1; j <= 15; j++) push_ev(s + 10 + 4 * j, 1 + j);
    wait_until(s + 3);
    bus.div_val  = 16'd4;
    bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    chk("t3_pend_not_applied", bus.div_cur, 10);
    wait_until(s + 9);
    chk("t3_before_wrap", bus.div_cur, 10);
    tick();
    chk("t3_after_wrap", bus.div_cur, 4);
    wait_until(s + 70);

    // 4: N=10, reload 8 pending, sync_restart at cnt=5 / os_cnt=9.
    bus.enable   = 1'b0;
    bus.div_val  = 16'd10;
    bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    tick();
    t = cyc;
    bus.enable = 1'b1;
    push_run(t, 10, 9);
    wait_until(t + 93);
    bus.div_val  = 16'd8;
    bus.div_load = 1'b1;
    tick();
    bus.div_load = 1'b0;
    chk("t4_pend_held", bus.div_cur, 10);
    tick();
    bus.sync_restart = 1'b1;
    tick();
    bus.sync_restart = 1'b0;
    chk("t4_restart_applies", bus.div_cur, 8);
    push_run(t + 96, 8, 16);
    // Second restart lands exactly on a wrap edge: that strobe must vanish.
    wait_until(t + 230);
    bus.div_val  = 16'd7;
    bus.div_load = 1'b1;
    tick();
    bus.div_load     = 1'b0;
    bus.sync_restart = 1'b1;
    chk("t4_pend7_held", bus.div_cur, 8);
    tick();
    bus.sync_restart = 1'b0;
    chk("t4_restart2_applies", bus.div_cur, 7);
    push_run(t + 232, 7, 8);

    // 5: async reset while tick_os is high.
    wait_until(t + 295);
    chk("t5_pre_reset_tick_os", bus.tick_os, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_async_tick_os", bus.tick_os, 0);
    chk("t5_async_div_cur", bus.div_cur, 27);
    tick();
    tick();
    reset_n = 1'b1;
    u = cyc;
    push_run(u, 27, 8);

    // 6: double load (last wins), then enable low for 3 cycles.
    wait_until(u + 219);
    bus.div_val  = 16'd9;
    bus.div_load = 1'b1;
    tick();
    bus.div_val  = 16'd5;
    tick();
    bus.div_load = 1'b0;
    chk("t6_pend_held_a", bus.div_cur, 27);
    tick();
    chk("t6_pend_held_b", bus.div_cur, 27);
    bus.enable = 1'b0;
    tick();
    chk("t6_idle_applies_last", bus.div_cur, 5);
    tick();
    tick();
    bus.enable = 1'b1;
    push_run(u + 225, 5, 16);
    wait_until(u + 305);
    bus.enable = 1'b0;
    tick();
    tick();
    tick();
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tick_gen
